shift_reg_univ: RTL
===================

Name: shift_reg_univ

Overview:
- Parametrised universal shift register; next generation of the fixed 8-bit load/rotate register.
- Adds configurable width, four shift modes, serial in/out, and multi-position shift-by-N.
- Shift-by-N runs as a start/busy/done sequenced operation, one position per clock.
- Used as a datapath/display-scroll element driven by a control FSM or a button-debounced start.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of shift-amount input. Amount range 0..2^AMT_W-1; amounts >= WIDTH are legal and simply keep shifting or rotating.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  parallel load request (honoured in IDLE only).
- pin  input  WIDTH  parallel load data.
- start  input  1  begin shift-by-N operation (honoured in IDLE only).
- mode  input  2  sampled with start: 00 rotate right, 01 rotate left, 10 shift right, 11 shift left.
- amt  input  AMT_W  number of one-position shifts, sampled with start.
- ser_in  input  1  fill bit for modes 10/11, sampled on every shift edge.
- Q  output  WIDTH  register contents.
- ser_out  output  1  next bit to leave: Q[0] for latched mode 00/10, Q[WIDTH-1] for 01/11.
- busy  output  1  high in SHIFT state.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): Q=0, state=IDLE, cnt=0, latched mode=00, busy=0, done=0. Therefore ser_out=Q[0]=0.
- Right shift/rotate is toward LSB: Q[i]<=Q[i+1]. MSB gets Q[0] (mode 00) or ser_in (mode 10).
- Left shift/rotate: Q[i]<=Q[i-1]. LSB gets Q[WIDTH-1] (mode 01) or ser_in (mode 11).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load=1: Q<=pin, stay IDLE. Load has priority; a simultaneous start is dropped.
  - else start=1, amt>0: latch mode, cnt<=amt, go SHIFT. Q unchanged on this edge.
  - else start=1, amt=0: latch mode, go DONE. Q unchanged.
  - else: hold Q.
- SHIFT:
  - Each edge performs one shift per the latched mode and does cnt<=cnt-1.
  - The edge with cnt==1 shifts and goes to DONE.
  - load, start, mode and amt are ignored.
- DONE: done=1 for exactly one cycle, Q held, next edge goes to IDLE. start/load are ignored in DONE.
- Latency: start sampled at edge E0. Shifts occur at edges E1..E_amt. busy is high from after E0 until E_amt. done is high in the cycle after E_amt. IDLE resumes at E_amt+1. For amt=0, done is high in the cycle after E0.
- A new start can be accepted at the earliest at edge E_amt+1.
- busy and done are registered, decoded from state, and never high together.
- Reset asserted mid-operation aborts immediately: all outputs take reset values, with no done pulse.

Optional Feature:
- Macro: SHIFT_REG_UNIV_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in SHIFT: the next edge goes to IDLE without shifting on that edge. Q retains its partially shifted value, cnt<=0, no done pulse.
  - abort in IDLE or DONE has no effect.
- Undefined: the port does not exist and SHIFT always runs to completion.

Test Plan:
- Reset: drive rst_n=0 mid-cycle -> Q=8'h00, busy=0, done=0 immediately, without waiting for a clock edge.
- Load 8'hA5, then start mode=00 amt=1 -> Q=8'hD2 after E1. done high one cycle later, busy high for exactly 1 cycle.
- Load 8'h81, then start mode=01 amt=3 -> Q sequence 8'h03, 8'h06, 8'h0C. busy high 3 cycles, then a single done pulse.
- Load 8'h00, ser_in=1, start mode=10 amt=4 -> Q=8'hF0. ser_out=0 throughout. Then load 8'hFF, ser_in=0, mode=11 amt=8 -> Q=8'h00, done in the cycle after E8.
- start with amt=0 on Q=8'h5A -> done in the next cycle, Q stays 8'h5A, busy never high. load=1 with start=1 -> Q=pin, no busy, no done.
- Ignore and abort: pulse load=1 pin=8'hFF during SHIFT -> ignored, Q follows the shift sequence only. Assert rst_n=0 at E2 of an amt=5 operation -> reset values, no done. With SHIFT_REG_UNIV_ABORT_EN, abort at E2 of an amt=5 rotate-right from 8'h01 -> Q=8'h40 held, IDLE, no done.

Source files
------------

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with start/busy/done shift-by-N sequencing
// Optional abort input enabled by defining SHIFT_REG_UNIV_ABORT_EN.
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             ser_in,
`ifdef SHIFT_REG_UNIV_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};
  localparam logic [AMT_W-1:0] CNT_ZERO = '0;

  logic [1:0]       r_state;
  logic [1:0]       r_mode;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;
  logic             w_abort;

`ifdef SHIFT_REG_UNIV_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Mode bit 0 selects direction (left), bit 1 selects serial fill instead of rotate.
  always_comb begin
    w_shifted = r_q;
    case (r_mode)
      2'b00:   w_shifted = {r_q[0], r_q[WIDTH-1:1]};
      2'b01:   w_shifted = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      2'b10:   w_shifted = {ser_in, r_q[WIDTH-1:1]};
      default: w_shifted = {r_q[WIDTH-2:0], ser_in};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 2'b00;
      r_cnt   <= CNT_ZERO;
      r_q     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_q <= pin;
          end else if (start) begin
            r_mode <= mode;
            if (amt != CNT_ZERO) begin
              r_cnt   <= amt;
              r_state <= S_SHIFT;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          if (w_abort) begin
            r_cnt   <= CNT_ZERO;
            r_state <= S_IDLE;
          end else begin
            r_q   <= w_shifted;
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Q       = r_q;
  assign ser_out = r_mode[0] ? r_q[WIDTH-1] : r_q[0];
  assign busy    = (r_state == S_SHIFT);
  assign done    = (r_state == S_DONE);

endmodule
